// File: rtl/axis_integrate_dump_pkg.sv
// Shared widths, lane types and width helpers for the integrate-and-dump stage.
package axis_integ_pkg;

  localparam int DEF_IN_SAMPLE_WIDTH = 16;
  localparam int DEF_SAMPLES         = 16;
  localparam int DEF_ACC_LOG2        = 4;
  localparam int DEF_FRAME_LEN       = 64;

  // Worst case sum is 2^log2 * (2^in_w - 1), which always fits in in_w + log2 bits.
  function automatic int acc_width_f(input int in_w, input int log2);
    return in_w + log2;
  endfunction

  function automatic int keep_width_f(input int samples, input int acc_w);
    return (samples * acc_w + 7) / 8;
  endfunction

  localparam int DEF_ACC_WIDTH  = acc_width_f(DEF_IN_SAMPLE_WIDTH, DEF_ACC_LOG2);
  localparam int DEF_KEEP_WIDTH = keep_width_f(DEF_SAMPLES, DEF_ACC_WIDTH);

  typedef logic [DEF_IN_SAMPLE_WIDTH-1:0] in_lane_t;
  typedef logic [DEF_ACC_WIDTH-1:0]       acc_lane_t;

endpackage

// File: rtl/axis_integrate_dump_lane.sv
// One lane of the integrate-and-dump stage: masked add into a private accumulator,
// cleared when the window's final beat is accepted.
module axis_integ_lane
  import axis_integ_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_SAMPLE_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 accept,
  input  logic                 final_beat,
  input  logic                 keep,
  input  logic [IN_WIDTH-1:0]  lane_in,
  output logic [ACC_WIDTH-1:0] sum_out
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] masked_s;

  always_comb begin
    if (keep) begin
      masked_s = ACC_WIDTH'(lane_in);
    end else begin
      masked_s = '0;
    end
    sum_out = acc_q + masked_s;
    acc_d   = acc_q;
    if (accept) begin
      if (final_beat) begin
        acc_d = '0;
      end else begin
        acc_d = sum_out;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/axis_integrate_dump.sv
// Per-lane integrate-and-dump with framed AXI-Stream output. Define AXIS_INTEG_TLAST_FLUSH_EN
// to let an input tlast force a partial dump that also closes the output frame.
module axis_integrate_dump
  import axis_integ_pkg::*;
#(
  parameter  int IN_SAMPLE_WIDTH = DEF_IN_SAMPLE_WIDTH,
  parameter  int SAMPLES         = DEF_SAMPLES,
  parameter  int ACC_LOG2        = DEF_ACC_LOG2,
  parameter  int FRAME_LEN       = DEF_FRAME_LEN,
  localparam int ACC_WIDTH       = acc_width_f(IN_SAMPLE_WIDTH, ACC_LOG2),
  localparam int KEEP_WIDTH      = keep_width_f(SAMPLES, ACC_WIDTH)
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [SAMPLES*IN_SAMPLE_WIDTH-1:0] s_axis_tdata,
  input  logic [SAMPLES-1:0]             s_axis_tkeep,
  input  logic                           s_axis_tlast,
  input  logic [ACC_LOG2:0]              integ_len,
  output logic [SAMPLES*ACC_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready
);

  localparam int LW = ACC_LOG2 + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LW-1:0] LEN_MAX    = LW'(2 ** ACC_LOG2);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  logic [LW-1:0]                len_q, len_d;
  logic [LW-1:0]                beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]                frame_cnt_q, frame_cnt_d;
  logic                         m_valid_q, m_valid_d;
  logic                         m_last_q, m_last_d;
  logic [SAMPLES*ACC_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0]        m_keep_q, m_keep_d;

  logic [LW-1:0]                len_in_s;
  logic [LW-1:0]                cur_len_s;
  logic                         flush_s;
  logic                         final_pos_s;
  logic                         accept_s;
  logic                         frame_end_s;
  logic [SAMPLES*ACC_WIDTH-1:0] sums_s;

`ifdef AXIS_INTEG_TLAST_FLUSH_EN
  assign flush_s = s_axis_tlast;
`else
  logic unused_tlast_s;
  assign unused_tlast_s = s_axis_tlast;
  assign flush_s        = 1'b0;
`endif

  // Window length for a window starting now, and whether the presented beat closes the window.
  always_comb begin
    if (integ_len == '0) begin
      len_in_s = LW'(1);
    end else if (integ_len > LEN_MAX) begin
      len_in_s = LEN_MAX;
    end else begin
      len_in_s = integ_len;
    end
    if (beat_cnt_q == '0) begin
      cur_len_s = len_in_s;
    end else begin
      cur_len_s = len_q;
    end
    final_pos_s = (beat_cnt_q == (cur_len_s - LW'(1))) || flush_s;
    frame_end_s = flush_s || (frame_cnt_q == FRAME_LAST);
  end

  // A final beat needs the output register free; other beats only touch the accumulators.
  assign s_axis_tready = !reset && (!final_pos_s || !m_valid_q || m_axis_tready);
  assign accept_s      = s_axis_tvalid && s_axis_tready;

  for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
    axis_integ_lane #(
      .IN_WIDTH  (IN_SAMPLE_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .CLK        (CLK),
      .reset      (reset),
      .accept     (accept_s),
      .final_beat (final_pos_s),
      .keep       (s_axis_tkeep[i]),
      .lane_in    (s_axis_tdata[i*IN_SAMPLE_WIDTH +: IN_SAMPLE_WIDTH]),
      .sum_out    (sums_s[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  always_comb begin
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    if (accept_s) begin
      if (beat_cnt_q == '0) begin
        len_d = len_in_s;
      end else begin
        len_d = len_q;
      end
      if (final_pos_s) begin
        beat_cnt_d = '0;
        m_valid_d  = 1'b1;
        m_data_d   = sums_s;
        m_keep_d   = '1;
        m_last_d   = frame_end_s;
        if (frame_end_s) begin
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end else begin
        beat_cnt_d = beat_cnt_q + LW'(1);
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      len_q       <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
    end else begin
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;

endmodule

// File: tb/tb_axis_integrate_dump.sv
// Randomized scoreboard bench for axis_integrate_dump (FRAME_LEN=4 instance).
module tb_axis_integrate_dump;
  import axis_integ_pkg::*;

  localparam int NS   = DEF_SAMPLES;
  localparam int IW   = DEF_IN_SAMPLE_WIDTH;
  localparam int AW   = DEF_ACC_WIDTH;
  localparam int KW   = DEF_KEEP_WIDTH;
  localparam int LMAX = 2 ** DEF_ACC_LOG2;
  localparam int FLEN = 4;

  typedef struct {
    logic [NS*AW-1:0] data;
    logic             last;
  } exp_t;

  logic              CLK = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [NS*IW-1:0]  s_data = '0;
  logic [NS-1:0]     s_keep = '0;
  logic              s_last = 1'b0;
  logic [DEF_ACC_LOG2:0] integ_len = '0;
  logic [NS*AW-1:0]  m_data;
  logic [KW-1:0]     m_keep;
  logic              m_last;
  logic              m_valid;
  logic              m_ready = 1'b0;

  axis_integrate_dump #(.FRAME_LEN(FLEN)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .integ_len     (integ_len),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready)
  );

  always #5 CLK = ~CLK;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Reference model state: beats collected in the open window and output position in frame.
  int        win_cnt = 0;
  int        win_len = 1;
  acc_lane_t win_sum[NS];
  int        out_pos = 0;

  // Handshake snapshot taken at the falling edge, consumed at the next rising edge.
  logic             cap_rst  = 1'b1;
  logic             cap_acc  = 1'b0;
  logic [NS*IW-1:0] cap_data = '0;
  logic [NS-1:0]    cap_keep = '0;
  logic             cap_last = 1'b0;
  int               cap_len  = 0;

  logic             stall_prev = 1'b0;
  logic [NS*AW-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;

  function automatic int clamp_len(input int v);
    if (v == 0) return 1;
    if (v > LMAX) return LMAX;
    return v;
  endfunction

  function automatic bit flush_en();
`ifdef AXIS_INTEG_TLAST_FLUSH_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [NS*AW-1:0] act, input logic [NS*AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    cap_rst  = reset;
    cap_acc  = s_valid && s_ready;
    cap_data = s_data;
    cap_keep = s_keep;
    cap_last = s_last;
    cap_len  = int'(integ_len);
  end

  // Reference model: accumulate accepted beats per window and queue the expected sum.
  always @(posedge CLK) begin
    if (cap_rst) begin
      sb.delete();
      win_cnt = 0;
      out_pos = 0;
      for (int i = 0; i < NS; i++) win_sum[i] = '0;
    end else if (cap_acc) begin
      exp_t e;
      bit   fl;
      if (win_cnt == 0) win_len = clamp_len(cap_len);
      for (int i = 0; i < NS; i++)
        if (cap_keep[i]) win_sum[i] = win_sum[i] + acc_lane_t'(cap_data[i*IW +: IW]);
      win_cnt++;
      fl = flush_en() && cap_last;
      if (win_cnt == win_len || fl) begin
        for (int i = 0; i < NS; i++) e.data[i*AW +: AW] = win_sum[i];
        e.last  = fl || (out_pos == FLEN - 1);
        out_pos = e.last ? 0 : out_pos + 1;
        sb.push_back(e);
        win_cnt = 0;
        for (int i = 0; i < NS; i++) win_sum[i] = '0;
      end
    end
  end

  // Monitor: output presence, input back-pressure, stall stability and scoreboard compare.
  always @(negedge CLK) begin
    if (!reset) begin
      bit fp;
      chk("out_valid", NS*AW'(m_valid), NS*AW'(sb.size() != 0));
      fp = (win_cnt == 0) ? (clamp_len(int'(integ_len)) == 1) : (win_cnt == win_len - 1);
      fp = fp || (flush_en() && s_last);
      if (s_valid)
        chk("in_ready", NS*AW'(s_ready), NS*AW'(!fp || sb.size() == 0 || m_ready));
      if (stall_prev && m_valid) begin
        chk("stall_data", m_data, prev_data);
        chk("stall_last", NS*AW'(m_last), NS*AW'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", NS*AW'(1), NS*AW'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", m_data, e.data);
          chk("out_last", NS*AW'(m_last), NS*AW'(e.last));
          chk("out_keep", NS*AW'(m_keep), NS*AW'({KW{1'b1}}));
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset();
    chk("rst_m_valid", NS*AW'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_keep", NS*AW'(m_keep), '0);
    chk("rst_m_last", NS*AW'(m_last), '0);
    chk("rst_s_ready", NS*AW'(s_ready), '0);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge CLK); #1;
    reset   = 1'b1;
    s_valid = 1'b0;
    repeat (cycles) @(posedge CLK);
    #1;
    check_reset();
    reset = 1'b0;
  endtask

  // len_mode < 0: random integ_len every cycle; data/keep < 0: random; rdy_pct < 0: 5-low/3-high pattern.
  task automatic run_phase(input int cycles, input int len_mode, input int data_mode,
                           input int keep_mode, input int rdy_pct, input int vld_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK); #1;
      if (!s_valid || cap_acc) begin
        s_valid = ($urandom_range(99, 0) < vld_pct);
        for (int i = 0; i < NS; i++)
          s_data[i*IW +: IW] = (data_mode < 0) ? IW'($urandom) : IW'(data_mode);
        s_keep = (keep_mode < 0) ? NS'($urandom) : NS'(keep_mode);
        s_last = ($urandom_range(5, 0) == 0);
      end
      integ_len = (len_mode < 0) ? 5'($urandom_range(31, 0)) : 5'(len_mode);
      if (rdy_pct < 0) m_ready = ((c % 8) >= 5);
      else             m_ready = ($urandom_range(99, 0) < rdy_pct);
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) win_sum[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset();
    reset = 1'b0;
    run_phase(40,  4,  100,     16'hFFFF, 100, 100);
    run_phase(80,  16, 16'hFFFF, 16'hFFFF, 100, 100);
    run_phase(40,  0,  -1,      -1,       90,  100);
    run_phase(80,  3,  -1,      16'hFFFF, -1,  100);
    run_phase(30,  2,  7,       16'h00FF, 100, 100);
    run_phase(300, -1, -1,      -1,       70,  80);
    run_phase(60,  25, -1,      -1,       80,  90);
    do_reset(2);
    run_phase(10,  1,  -1,      -1,       100, 100);
    do_reset(1);
    run_phase(6,   4,  100,     16'hFFFF, 100, 100);
    do_reset(2);
    run_phase(40,  4,  -1,      -1,       100, 100);
    run_phase(200, -1, -1,      -1,       40,  90);
    run_phase(3,   1,  -1,      -1,       0,   100);
    do_reset(2);
    run_phase(200, -1, -1,      -1,       60,  70);
    // Drain any pending output, then nothing may remain queued.
    run_phase(12, 4, -1, -1, 100, 0);
    #1;
    chk("drain_empty", NS*AW'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
